// File: rtl/twiddle_sched.sv
// Twiddle-factor scheduler for a radix-2 FFT: walks stage/sample counters,
// addresses the twiddle ROM and registers the multiplier product under valid/ready.
module twiddle_sched #(
    parameter int N_LOG2 = 4,
    parameter int W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [W-1:0]      in_data,
    output logic              in_ready,
    output logic [N_LOG2-2:0] tw_addr,
    input  logic [W-1:0]      tw_data,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [W-1:0]      mul_out,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    input  logic              out_ready,
    output logic [N_LOG2-1:0] stage,
    output logic              busy,
    output logic              done
);

    localparam int JW                  = N_LOG2 - 1;
    localparam int HALF                = 1 << JW;
    localparam logic [JW-1:0] J_LAST   = JW'(HALF - 1);
    localparam logic [N_LOG2-1:0] S_LAST = N_LOG2'(N_LOG2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        state;
    logic [JW-1:0] j;
    logic          xfer;
    logic          last_xfer;
    int            tw_span;

    // A new sample may enter only if the output register is free or draining now.
    // The twiddle stride doubles each stage while the span of distinct factors halves.
    always_comb begin
        in_ready  = (state == RUN) && (!out_valid || out_ready);
        xfer      = in_valid && in_ready;
        last_xfer = xfer && (j == J_LAST) && (stage == S_LAST);
        tw_span   = HALF >> stage;
        tw_addr   = JW'((int'(j) & (tw_span - 1)) << stage);
    end

    assign busy  = (state != IDLE);
    assign mul_a = in_data;
    assign mul_b = tw_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            j         <= '0;
            stage     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (xfer) begin
                out_data  <= mul_out;
                out_valid <= 1'b1;
                if (j == J_LAST) begin
                    j     <= '0;
                    stage <= (stage == S_LAST) ? '0 : stage + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        j     <= '0;
                        stage <= '0;
                    end
                end
                RUN: begin
                    if (last_xfer) state <= FLUSH;
                end
                FLUSH: begin
                    // Frame ends once the last product has been taken downstream.
                    if (!out_valid || out_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        j     <= '0;
                        stage <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twiddle_sched.sv
// Directed bench for twiddle_sched: bench-side twiddle ROM and Q10 complex multiplier,
// table-driven frame/datapath vectors plus stall, restart and reset sequences.
module tb_twiddle_sched;

    localparam int N_LOG2 = 4;
    localparam int W      = 24;
    localparam int FRAME  = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          inValid;
    logic [W-1:0]  inData;
    logic          inReady;
    logic [2:0]    twAddr;
    logic [W-1:0]  twData;
    logic [W-1:0]  mulA;
    logic [W-1:0]  mulB;
    logic [W-1:0]  mulOut;
    logic          outValid;
    logic [W-1:0]  outData;
    logic          outReady;
    logic [3:0]    stage;
    logic          busy;
    logic          done;

    logic          twForce;
    logic [W-1:0]  twForceVal;

    int checks;
    int errors;

    typedef struct {
        logic [W-1:0] din;
        logic [2:0]   addr;
        logic [3:0]   stg;
    } frame_t;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] tw;
        logic [W-1:0] expOut;
    } dp_t;

    frame_t frame[FRAME];
    dp_t    dpVec[6];

    twiddle_sched #(.N_LOG2(N_LOG2), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (inValid),
        .in_data   (inData),
        .in_ready  (inReady),
        .tw_addr   (twAddr),
        .tw_data   (twData),
        .mul_a     (mulA),
        .mul_b     (mulB),
        .mul_out   (mulOut),
        .out_valid (outValid),
        .out_data  (outData),
        .out_ready (outReady),
        .stage     (stage),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Q10 complex product, truncated by arithmetic shift and wrapped to 12 bits per half.
    function automatic logic [W-1:0] cmul(input logic [W-1:0] a, input logic [W-1:0] b);
        int ar, ai, br, bi, re, im;
        ar = int'($signed(a[23:12]));
        ai = int'($signed(a[11:0]));
        br = int'($signed(b[23:12]));
        bi = int'($signed(b[11:0]));
        re = (ar * br - ai * bi) >>> 10;
        im = (ar * bi + ai * br) >>> 10;
        return {re[11:0], im[11:0]};
    endfunction

    function automatic logic [W-1:0] rom(input logic [2:0] addr);
        int a, re, im;
        a  = int'(addr);
        re = 256 + 64 * a;
        im = -32 * a;
        return {re[11:0], im[11:0]};
    endfunction

    assign twData = twForce ? twForceVal : rom(twAddr);
    assign mulOut = cmul(mulA, mulB);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic iv, input logic [W-1:0] d, input logic ordy);
        start    = st;
        inValid  = iv;
        inData   = d;
        outReady = ordy;
    endtask

    function automatic logic [W-1:0] expOut(input int k);
        return cmul(frame[k].din, rom(frame[k].addr));
    endfunction

    task automatic runFrame(input int stallK, input int stallLen, input int startK, input int flushStall);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        #1 checkOutput("busy_at_run", 32'(busy), 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            if (k == stallK) begin
                for (int s = 0; s < stallLen; s++) begin
                    applyStimulus(1'b0, 1'b1, frame[k].din, 1'b0);
                    #1;
                    checkOutput("stall_in_ready", 32'(inReady), 32'd0);
                    checkOutput("stall_out_data", 32'(outData), 32'(expOut(k - 1)));
                    checkOutput("stall_tw_addr", 32'(twAddr), 32'(frame[k].addr));
                    checkOutput("stall_stage", 32'(stage), 32'(frame[k].stg));
                    @(negedge clk);
                end
            end
            applyStimulus(k == startK, 1'b1, frame[k].din, 1'b1);
            #1;
            checkOutput("in_ready", 32'(inReady), 32'd1);
            checkOutput("tw_addr", 32'(twAddr), 32'(frame[k].addr));
            checkOutput("stage", 32'(stage), 32'(frame[k].stg));
            @(negedge clk);
            start = 1'b0;
            checkOutput("out_valid", 32'(outValid), 32'd1);
            checkOutput("out_data", 32'(outData), 32'(expOut(k)));
            checkOutput("done_mid", 32'(done), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, '0, flushStall == 0);
        for (int s = 0; s < flushStall; s++) begin
            #1;
            checkOutput("flush_busy", 32'(busy), 32'd1);
            checkOutput("flush_done", 32'(done), 32'd0);
            checkOutput("flush_out_valid", 32'(outValid), 32'd1);
            checkOutput("flush_out_data", 32'(outData), 32'(expOut(FRAME - 1)));
            @(negedge clk);
        end
        outReady = 1'b1;
        #1 checkOutput("flush_busy_release", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("out_valid_after", 32'(outValid), 32'd0);
        checkOutput("stage_after", 32'(stage), 32'd0);
        checkOutput("tw_addr_after", 32'(twAddr), 32'd0);
        @(negedge clk);
        checkOutput("done_single", 32'(done), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(outValid), 32'd0);
        checkOutput({tag, "_out_data"}, 32'(outData), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(inReady), 32'd0);
        checkOutput({tag, "_tw_addr"}, 32'(twAddr), 32'd0);
        checkOutput({tag, "_stage"}, 32'(stage), 32'd0);
    endtask

    initial begin
        logic [2:0] addrTab[FRAME];
        int re, im;

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        twForce    = 1'b0;
        twForceVal = '0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        addrTab = '{0, 1, 2, 3, 4, 5, 6, 7,
                    0, 2, 4, 6, 0, 2, 4, 6,
                    0, 4, 0, 4, 0, 4, 0, 4,
                    0, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < FRAME; k++) begin
            re = 100 + 37 * k;
            im = -50 - 13 * k;
            frame[k].din  = {re[11:0], im[11:0]};
            frame[k].addr = addrTab[k];
            frame[k].stg  = 4'(k / 8);
        end

        dpVec[0] = '{{12'sd1024, 12'sd0},    {12'sd724, -12'sd724}, {12'sd724, -12'sd724}};
        dpVec[1] = '{{12'sd512, 12'sd512},   {12'sd1024, 12'sd0},   {12'sd512, 12'sd512}};
        dpVec[2] = '{{12'sd0, 12'sd1024},    {12'sd0, 12'sd1024},   {-12'sd1024, 12'sd0}};
        dpVec[3] = '{{-12'sd2048, 12'sd100}, {12'sd1024, 12'sd0},   {-12'sd2048, 12'sd100}};
        dpVec[4] = '{{12'sd300, -12'sd200},  {12'sd512, 12'sd512},  {12'sd250, 12'sd50}};
        dpVec[5] = '{{-12'sd1, 12'sd0},      {12'sd1, 12'sd0},      {-12'sd1, 12'sd0}};

        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        $display("[TB] full frame, no backpressure");
        runFrame(-1, 0, -1, 0);

        $display("[TB] frame with stall at j=3, start at stage1 j=5, flush stall");
        runFrame(3, 5, 13, 3);

        $display("[TB] datapath vectors then mid-frame reset");
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        start   = 1'b0;
        twForce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, dpVec[i].din, 1'b1);
            twForceVal = dpVec[i].tw;
            @(negedge clk);
            checkOutput("dp_out_valid", 32'(outValid), 32'd1);
            checkOutput("dp_out_data", 32'(outData), 32'(dpVec[i].expOut));
        end
        twForce = 1'b0;
        rst     = 1'b1;
        applyStimulus(1'b1, 1'b1, frame[0].din, 1'b1);
        repeat (2) @(negedge clk);
        checkResetState("midreset");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, frame[0].din, 1'b1);
        #1 checkOutput("idle_in_ready", 32'(inReady), 32'd0);
        @(negedge clk);
        checkOutput("idle_no_accept", 32'(outValid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        $display("[TB] start together with in_valid in IDLE");
        applyStimulus(1'b1, 1'b1, frame[1].din, 1'b1);
        #1 checkOutput("start_in_ready", 32'(inReady), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("start_no_accept", 32'(outValid), 32'd0);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_stage", 32'(stage), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/twiddle_sched.md
TWIDDLE_SCHED -- requirements
Module: twiddle_sched

Interface
REQ-001 Parameter N_LOG2, default 4, log2 of FFT size N (N=16).
REQ-002 Parameter W, default 24, packed complex sample width: {re[W-1:W/2], im[W/2-1:0]}, each half signed 12.10.
REQ-003 The design SHALL use one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame; honoured in IDLE only.
REQ-007 in_valid  input  1  butterfly output sample valid.
REQ-008 in_data  input  W  butterfly output sample.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 tw_addr  output  N_LOG2-1  twiddle ROM address.
REQ-011 tw_data  input  W  twiddle ROM data, combinational from tw_addr in the same cycle.
REQ-012 mul_a  output  W  complex multiplier operand C; equals in_data.
REQ-013 mul_b  output  W  complex multiplier operand T; equals tw_data.
REQ-014 mul_out  input  W  complex multiplier product, combinational.
REQ-015 out_valid  output  1  out_data valid.
REQ-016 out_data  output  W  registered twiddled sample.
REQ-017 out_ready  input  1  downstream accepts out_data.
REQ-018 stage  output  N_LOG2 bits (clog2 of N_LOG2+1 minimum)  current FFT stage index.
REQ-019 busy  output  1  high in RUN and FLUSH.
REQ-020 done  output  1  one-cycle end-of-frame pulse.

Function
REQ-021 The FSM SHALL have three states: IDLE, RUN and FLUSH.
- IDLE->RUN on start.
- RUN->FLUSH on acceptance of the final sample of the final stage.
- FLUSH->IDLE when out_valid is 0 or out_valid&&out_ready.
REQ-022 Handshakes:
- in_ready = (state==RUN) && (!out_valid || out_ready).
- An input transfer occurs on in_valid && in_ready.
REQ-023 Each stage SHALL accept N/2 samples; sample counter j runs 0..N/2-1, increments per transfer, and wraps to 0 with stage+1 at j==N/2-1.
REQ-024 tw_addr = (j mod (N >> (stage+1))) << stage, combinational from j and stage; it is 0 throughout the last stage.
REQ-025 On a transfer, out_data SHALL load mul_out bit-exact (no rounding or saturation) and out_valid SHALL be set: latency 1 cycle.
REQ-026 out_valid SHALL clear on out_valid && out_ready with no simultaneous transfer; a simultaneous transfer keeps out_valid=1 and loads new data.
REQ-027 While out_valid && !out_ready, out_data, j, stage and tw_addr SHALL hold.
REQ-028 Total frame length is N_LOG2*N/2 transfers (32 for defaults).
REQ-029 done SHALL assert for exactly one cycle, in the cycle after the FLUSH->IDLE condition is met; busy SHALL be 0 in that same cycle.
REQ-030 On leaving FLUSH, stage and j SHALL return to 0.
REQ-031 start while busy SHALL be ignored.
REQ-032 start in IDLE together with in_valid: that sample is not accepted, because in_ready=0 in IDLE.
REQ-033 in_valid outside RUN SHALL be ignored.

Reset
REQ-034 rst SHALL force state=IDLE, j=0, stage=0, out_valid=0, out_data=0, done=0, busy=0, in_ready=0 and tw_addr=0 on the next edge, including mid-frame; partial frame results are discarded.
REQ-035 rst SHALL take priority over start and over all handshakes in the same cycle.

Verification
REQ-036 Reset: rst=1 for 2 cycles during RUN -> all outputs 0 and state IDLE; in_valid=1 afterwards is not accepted.
REQ-037 Full frame, in_valid=1, out_ready=1 -> tw_addr sequence:
- stage0: 0..7
- stage1: 0,2,4,6,0,2,4,6
- stage2: 0,4,0,4,0,4,0,4
- stage3: eight 0s
- Expected: 32 outputs, then done high 1 cycle, busy low.
REQ-038 Data path: in_data={12'sd1024,12'sd0}, tw_data={12'sd724,-12'sd724}, bench multiplier returns {724,-724} -> out_data={12'sd724,-12'sd724} one cycle later.
REQ-039 Backpressure: out_ready=0 for 5 cycles at j=3 -> in_ready=0, out_data/tw_addr/stage stable; on release, throughput resumes at 1 sample/cycle with no loss or duplication.
REQ-040 start pulsed at j=5, stage=1 -> ignored; the frame still completes after 32 transfers with a single done.
REQ-041 Final output stalled by out_ready=0 for 3 cycles in FLUSH -> busy=1 and done=0 until acceptance; done follows on the next cycle.
